// File: rtl/audio_mem_pkg.sv
// Shared types for the audio record/playback path: FSM state codes and
// the packed stereo frame layout used in memory.
package audio_mem_pkg;

    localparam int AUDIO_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CAP   = 3'd1,
        ST_WR    = 3'd2,
        ST_RD    = 3'd3,
        ST_RWAIT = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // One stereo frame as stored in one memory word: L upper, R lower.
    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] l;
        logic [AUDIO_DATA_W-1:0] r;
    } frame_t;

endpackage

// File: rtl/audio_frame_capture.sv
// Two-channel ready/valid capture: each channel accepts one sample
// independently and holds it until the frame is cleared.
module audio_frame_capture #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_pause,
    input  logic              i_clear,
    input  logic              i_l_valid,
    input  logic [DATA_W-1:0] i_l_data,
    output logic              o_l_ready,
    input  logic              i_r_valid,
    input  logic [DATA_W-1:0] i_r_data,
    output logic              o_r_ready,
    output logic [DATA_W-1:0] o_l_data,
    output logic [DATA_W-1:0] o_r_data,
    output logic              o_complete
);

    // Index 1 is the left channel, index 0 the right channel.
    logic [1:0]        valid_in;
    logic [1:0]        ready_out;
    logic [1:0]        held;
    logic [DATA_W-1:0] data_in  [2];
    logic [DATA_W-1:0] data_out [2];

    assign valid_in   = {i_l_valid, i_r_valid};
    assign data_in[1] = i_l_data;
    assign data_in[0] = i_r_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic              held_reg;
            logic [DATA_W-1:0] data_reg;

            assign ready_out[gi] = i_enable && !i_pause && !held_reg;
            assign held[gi]      = held_reg;
            assign data_out[gi]  = data_reg;

            // Take one sample per frame; a clear drops the flag but keeps the data.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    held_reg <= 1'b0;
                    data_reg <= '0;
                end else if (i_clear) begin
                    held_reg <= 1'b0;
                end else if (valid_in[gi] && ready_out[gi]) begin
                    held_reg <= 1'b1;
                    data_reg <= data_in[gi];
                end
            end
        end
    endgenerate

    assign o_l_ready  = ready_out[1];
    assign o_r_ready  = ready_out[0];
    assign o_l_data   = data_out[1];
    assign o_r_data   = data_out[0];
    assign o_complete = &held;

endmodule

// File: rtl/audio_mem_recorder.sv
// Stereo record/playback engine between the codec streaming ports and an
// Avalon-MM memory slave: frames {L,R} go to consecutive words.
module audio_mem_recorder
    import audio_mem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 23,
    parameter int MAX_WORDS = 2**ADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_record,
    input  logic                i_play,
    input  logic                i_stop,
    input  logic                i_pause,
    input  logic                i_loop,
    output logic                o_adc_l_ready,
    output logic                o_adc_r_ready,
    input  logic                i_adc_l_valid,
    input  logic                i_adc_r_valid,
    input  logic [DATA_W-1:0]   i_adc_l_data,
    input  logic [DATA_W-1:0]   i_adc_r_data,
    output logic                o_dac_l_valid,
    output logic                o_dac_r_valid,
    input  logic                i_dac_l_ready,
    input  logic                i_dac_r_ready,
    output logic [DATA_W-1:0]   o_dac_l_data,
    output logic [DATA_W-1:0]   o_dac_r_data,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic [2*DATA_W-1:0] o_mem_writedata,
    input  logic [2*DATA_W-1:0] i_mem_readdata,
    input  logic                i_mem_readdatavalid,
    input  logic                i_mem_waitrequest,
    output logic [ADDR_W-1:0]   o_rec_len,
    output logic [2:0]          o_state,
    output logic                o_full
);

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } word_t;

    // Frame counters carry one extra bit so a full memory (MAX_WORDS) is representable.
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W:0]   rec_len_reg, rec_len_next;
    logic              full_reg, full_next;
    logic              stop_pend_reg, stop_pend_next;
    logic              rd_busy_reg, rd_busy_next;
    word_t             rd_word_reg, rd_word_next;
    logic              dac_l_valid_reg, dac_l_valid_next;
    logic              dac_r_valid_reg, dac_r_valid_next;

    logic              cap_clear;
    logic              cap_complete;
    logic [DATA_W-1:0] cap_l_data, cap_r_data;
    logic              mem_read, mem_write;
    logic [ADDR_W:0]   addr_inc;
    logic [ADDR_W:0]   rec_len_inc;

    audio_frame_capture #(.DATA_W(DATA_W)) u_capture (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enable   (state_reg == ST_CAP),
        .i_pause    (i_pause),
        .i_clear    (cap_clear),
        .i_l_valid  (i_adc_l_valid),
        .i_l_data   (i_adc_l_data),
        .o_l_ready  (o_adc_l_ready),
        .i_r_valid  (i_adc_r_valid),
        .i_r_data   (i_adc_r_data),
        .o_r_ready  (o_adc_r_ready),
        .o_l_data   (cap_l_data),
        .o_r_data   (cap_r_data),
        .o_complete (cap_complete)
    );

    assign addr_inc    = {1'b0, addr_reg} + CNT_ONE;
    assign rec_len_inc = rec_len_reg + CNT_ONE;

    // Next-state and datapath updates; a started bus cycle is always finished.
    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        rec_len_next     = rec_len_reg;
        full_next        = full_reg;
        stop_pend_next   = stop_pend_reg;
        rd_busy_next     = rd_busy_reg;
        rd_word_next     = rd_word_reg;
        dac_l_valid_next = dac_l_valid_reg;
        dac_r_valid_next = dac_r_valid_reg;
        cap_clear        = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                stop_pend_next = 1'b0;
                rd_busy_next   = 1'b0;
                if (i_record) begin
                    state_next   = ST_CAP;
                    addr_next    = '0;
                    rec_len_next = '0;
                    full_next    = 1'b0;
                end else if (i_play && (rec_len_reg != '0)) begin
                    state_next = ST_RD;
                    addr_next  = '0;
                end
            end
            ST_CAP: begin
                if (i_stop) begin
                    state_next = ST_IDLE;
                    cap_clear  = 1'b1;
                end else if (cap_complete) begin
                    state_next = ST_WR;
                    cap_clear  = 1'b1;
                end
            end
            ST_WR: begin
                mem_write = 1'b1;
                if (i_stop) stop_pend_next = 1'b1;
                if (!i_mem_waitrequest) begin
                    addr_next    = addr_inc[ADDR_W-1:0];
                    rec_len_next = rec_len_inc;
                    if (rec_len_inc == MAX_CNT) begin
                        full_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else if (i_stop || stop_pend_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_CAP;
                    end
                end
            end
            ST_RD: begin
                // Pause only blocks starting a read; a stalled read is held to completion.
                mem_read = !i_pause || rd_busy_reg;
                if (i_stop && !mem_read) begin
                    state_next = ST_IDLE;
                end else if (mem_read) begin
                    if (i_stop) stop_pend_next = 1'b1;
                    if (!i_mem_waitrequest) begin
                        rd_busy_next = 1'b0;
                        state_next   = ST_RWAIT;
                    end else begin
                        rd_busy_next = 1'b1;
                    end
                end
            end
            ST_RWAIT: begin
                if (i_stop) stop_pend_next = 1'b1;
                if (i_mem_readdatavalid) begin
                    if (i_stop || stop_pend_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        rd_word_next     = i_mem_readdata;
                        dac_l_valid_next = 1'b1;
                        dac_r_valid_next = 1'b1;
                        state_next       = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                dac_l_valid_next = dac_l_valid_reg && !i_dac_l_ready;
                dac_r_valid_next = dac_r_valid_reg && !i_dac_r_ready;
                if (i_stop) begin
                    dac_l_valid_next = 1'b0;
                    dac_r_valid_next = 1'b0;
                    state_next       = ST_IDLE;
                end else if (!dac_l_valid_next && !dac_r_valid_next) begin
                    if (addr_inc == rec_len_reg) begin
                        if (i_loop) begin
                            addr_next  = '0;
                            state_next = ST_RD;
                        end else begin
                            addr_next  = addr_inc[ADDR_W-1:0];
                            state_next = ST_IDLE;
                        end
                    end else begin
                        addr_next  = addr_inc[ADDR_W-1:0];
                        state_next = ST_RD;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any bus cycle in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            rec_len_reg     <= '0;
            full_reg        <= 1'b0;
            stop_pend_reg   <= 1'b0;
            rd_busy_reg     <= 1'b0;
            rd_word_reg     <= '0;
            dac_l_valid_reg <= 1'b0;
            dac_r_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            rec_len_reg     <= rec_len_next;
            full_reg        <= full_next;
            stop_pend_reg   <= stop_pend_next;
            rd_busy_reg     <= rd_busy_next;
            rd_word_reg     <= rd_word_next;
            dac_l_valid_reg <= dac_l_valid_next;
            dac_r_valid_reg <= dac_r_valid_next;
        end
    end

    assign o_mem_addr      = addr_reg;
    assign o_mem_read      = mem_read;
    assign o_mem_write     = mem_write;
    assign o_mem_writedata = {cap_l_data, cap_r_data};
    assign o_dac_l_valid   = dac_l_valid_reg;
    assign o_dac_r_valid   = dac_r_valid_reg;
    assign o_dac_l_data    = rd_word_reg.l;
    assign o_dac_r_data    = rd_word_reg.r;
    // When memory is completely full the count's top bit is not visible here.
    assign o_rec_len       = rec_len_reg[ADDR_W-1:0];
    assign o_state         = state_reg;
    assign o_full          = full_reg;

endmodule

// File: tb/tb_audio_mem_recorder.sv
// Scoreboard bench: expected writes, read addresses and DAC samples are
// queued when stimulus is driven and popped when the DUT produces them.
module tb_audio_mem_recorder;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 4;
    localparam int FW        = 2*DATA_W;
    localparam logic [2:0] S_IDLE = 3'd0, S_CAP = 3'd1, S_WR = 3'd2,
                           S_RD = 3'd3, S_RWAIT = 3'd4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rec_in = 1'b0, play_in = 1'b0, stop_in = 1'b0;
    logic              pause_in = 1'b0, loop_in = 1'b0;
    logic              adc_l_ready, adc_r_ready;
    logic              adc_l_valid = 1'b0, adc_r_valid = 1'b0;
    logic [DATA_W-1:0] adc_l_data = '0, adc_r_data = '0;
    logic              dac_l_valid, dac_r_valid;
    logic              dac_l_ready = 1'b1, dac_r_ready = 1'b1;
    logic [DATA_W-1:0] dac_l_data, dac_r_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read, mem_write;
    logic [FW-1:0]     mem_wdata;
    logic [FW-1:0]     mem_rdata = '0;
    logic              mem_rdv = 1'b0;
    logic              mem_wait = 1'b1;
    logic [ADDR_W-1:0] rec_len;
    logic [2:0]        state;
    logic              full;

    always #5 clk = ~clk;

    audio_mem_recorder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .i_clk(clk), .i_rst(rst), .i_record(rec_in), .i_play(play_in), .i_stop(stop_in),
        .i_pause(pause_in), .i_loop(loop_in),
        .o_adc_l_ready(adc_l_ready), .o_adc_r_ready(adc_r_ready),
        .i_adc_l_valid(adc_l_valid), .i_adc_r_valid(adc_r_valid),
        .i_adc_l_data(adc_l_data), .i_adc_r_data(adc_r_data),
        .o_dac_l_valid(dac_l_valid), .o_dac_r_valid(dac_r_valid),
        .i_dac_l_ready(dac_l_ready), .i_dac_r_ready(dac_r_ready),
        .o_dac_l_data(dac_l_data), .o_dac_r_data(dac_r_data),
        .o_mem_addr(mem_addr), .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_mem_writedata(mem_wdata), .i_mem_readdata(mem_rdata),
        .i_mem_readdatavalid(mem_rdv), .i_mem_waitrequest(mem_wait),
        .o_rec_len(rec_len), .o_state(state), .o_full(full)
    );

    int errors = 0;
    int checks = 0;
    int wait_cycles = 1;
    int rd_lat = 2;
    int wcnt = 0;
    int rd_cnt = 0;
    int read_count = 0;
    int write_count = 0;
    int dac_mode = 0;
    bit phase = 1'b0;
    logic [ADDR_W-1:0]    rd_addr = '0;
    logic [ADDR_W-1:0]    exp_addr = '0;
    logic [ADDR_W+FW-1:0] wexp;
    logic [ADDR_W-1:0]    rexp;
    logic [DATA_W-1:0]    dexp;
    logic [FW-1:0]        mem [0:255];

    logic [ADDR_W+FW-1:0] exp_w_q [$];
    logic [ADDR_W-1:0]    exp_rd_q [$];
    logic [DATA_W-1:0]    exp_l_q [$];
    logic [DATA_W-1:0]    exp_r_q [$];

    // Memory slave: stalls each access wait_cycles, returns read data rd_lat later.
    always @(posedge clk) begin
        #1;
        mem_rdv = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_rdv   = 1'b1;
                mem_rdata = mem[rd_addr];
            end
        end
        if (mem_read || mem_write) begin
            if (wcnt < wait_cycles) begin
                mem_wait = 1'b1;
                wcnt++;
            end else begin
                mem_wait = 1'b0;
                wcnt = 0;
                if (mem_write) begin
                    mem[mem_addr] = mem_wdata;
                    write_count++;
                    checks++;
                    if (exp_w_q.size() == 0) begin
                        errors++;
                        $display("FAIL wr_unexpected: got addr=%0h data=%h, required no write", mem_addr, mem_wdata);
                    end else begin
                        wexp = exp_w_q.pop_front();
                        if ({mem_addr, mem_wdata} !== wexp)
                        begin
                            errors++;
                            $display("FAIL wr_data: got addr=%0h data=%h, required addr=%0h data=%h",
                                     mem_addr, mem_wdata, wexp[ADDR_W+FW-1:FW], wexp[FW-1:0]);
                        end
                    end
                    $display("write addr=%0h data=%h", mem_addr, mem_wdata);
                end else begin
                    rd_addr = mem_addr;
                    rd_cnt  = rd_lat;
                    read_count++;
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_unexpected: got addr=%0h, required no read", mem_addr);
                    end else begin
                        rexp = exp_rd_q.pop_front();
                        if (mem_addr !== rexp) begin
                            errors++;
                            $display("FAIL rd_addr: got %0h, required %0h", mem_addr, rexp);
                        end
                    end
                    checks++;
                    if ({dac_l_valid, dac_r_valid} !== 2'b00) begin
                        errors++;
                        $display("FAIL rd_early: dac valids=%b, required 00", {dac_l_valid, dac_r_valid});
                    end
                    $display("read addr=%0h", mem_addr);
                end
            end
        end else begin
            wcnt = 0;
            mem_wait = (wait_cycles != 0);
        end
    end

    // DAC sink: always ready, or ready alternating left then right.
    always @(posedge clk) begin
        #1;
        phase = ~phase;
        if (dac_mode == 0) begin
            dac_l_ready = 1'b1;
            dac_r_ready = 1'b1;
        end else begin
            dac_l_ready = phase;
            dac_r_ready = ~phase;
        end
    end

    // DAC monitor: a sample counts when valid and ready meet before the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (dac_l_valid && dac_l_ready) begin
                checks++;
                if (exp_l_q.size() == 0) begin
                    errors++;
                    $display("FAIL dac_l_unexpected: got %h, required none", dac_l_data);
                end else begin
                    dexp = exp_l_q.pop_front();
                    if (dac_l_data !== dexp) begin
                        errors++;
                        $display("FAIL dac_l_data: got %h, required %h", dac_l_data, dexp);
                    end
                end
                $display("dac L %h", dac_l_data);
            end
            if (dac_r_valid && dac_r_ready) begin
                checks++;
                if (exp_r_q.size() == 0) begin
                    errors++;
                    $display("FAIL dac_r_unexpected: got %h, required none", dac_r_data);
                end else begin
                    dexp = exp_r_q.pop_front();
                    if (dac_r_data !== dexp) begin
                        errors++;
                        $display("FAIL dac_r_data: got %h, required %h", dac_r_data, dexp);
                    end
                end
                $display("dac R %h", dac_r_data);
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input int max_cycles, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < max_cycles && !hit; i++) begin
            @(negedge clk);
            if (state === s) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: state=%0d, required %0d within %0d cycles", name, state, s, max_cycles);
        end
    endtask

    task automatic wait_writes(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (exp_w_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL writes_pending: %0d left, required 0", exp_w_q.size());
        end
    endtask

    // which: 0 record, 1 play, 2 stop; one-cycle pulse.
    task automatic pulse(input int which);
        @(posedge clk); #1;
        if (which == 0) rec_in = 1'b1; else if (which == 1) play_in = 1'b1; else stop_in = 1'b1;
        @(posedge clk); #1;
        rec_in = 1'b0; play_in = 1'b0; stop_in = 1'b0;
    endtask

    task automatic send_ch(input bit is_l, input logic [DATA_W-1:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (is_l) begin adc_l_valid = 1'b1; adc_l_data = d; end
        else      begin adc_r_valid = 1'b1; adc_r_data = d; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (is_l ? adc_l_ready : adc_r_ready) got = 1'b1;
        end
        @(posedge clk); #1;
        adc_l_valid = 1'b0; adc_r_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL adc_handshake: ready=0, required 1 within 100 cycles");
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input bit r_first);
        exp_w_q.push_back({exp_addr, l, r});
        exp_addr++;
        if (r_first) begin send_ch(1'b0, r); send_ch(1'b1, l); end
        else         begin send_ch(1'b1, l); send_ch(1'b0, r); end
    endtask

    task automatic start_record();
        exp_addr = '0;
        pulse(0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({state, mem_read, mem_write, dac_l_valid, dac_r_valid, adc_l_ready, adc_r_ready, full} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got st=%0d rd=%b wr=%b dv=%b%b ar=%b%b full=%b, required all 0",
                     state, mem_read, mem_write, dac_l_valid, dac_r_valid, adc_l_ready, adc_r_ready, full);
        end
        checks++;
        if ({mem_addr, rec_len} !== '0) begin
            errors++;
            $display("FAIL reset_addr: got addr=%0h rec_len=%0d, required 0/0", mem_addr, rec_len);
        end
        checks++;
        if ({mem_wdata, dac_l_data, dac_r_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got wd=%h dl=%h dr=%h, required 0", mem_wdata, dac_l_data, dac_r_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_record();
        wait_cycles = 1;
        start_record();
        send_frame(16'h1111, 16'h2222, 1'b0);
        send_frame(16'h3333, 16'h4444, 1'b1);
        send_frame(16'h5555, 16'h6666, 1'b0);
        wait_writes(100);
        wait_state(S_CAP, 20, "record_cap");
        pulse(2);
        wait_state(S_IDLE, 20, "record_idle");
        checks++;
        if (rec_len !== 8'd3 || full !== 1'b0) begin
            errors++;
            $display("FAIL record_len: got rec_len=%0d full=%b, required 3/0", rec_len, full);
        end
    endtask

    task automatic test_playback();
        wait_cycles = 4;
        dac_mode = 1;
        for (int i = 0; i < 3; i++) exp_rd_q.push_back(ADDR_W'(i));
        exp_l_q.push_back(16'h1111); exp_r_q.push_back(16'h2222);
        exp_l_q.push_back(16'h3333); exp_r_q.push_back(16'h4444);
        exp_l_q.push_back(16'h5555); exp_r_q.push_back(16'h6666);
        pulse(1);
        checks++;
        if (mem_read !== 1'b1 || state !== S_RD) begin
            errors++;
            $display("FAIL play_latency: got read=%b st=%0d, required 1/%0d", mem_read, state, S_RD);
        end
        wait_state(S_IDLE, 300, "play_idle");
        checks++;
        if (exp_rd_q.size() + exp_l_q.size() + exp_r_q.size() != 0) begin
            errors++;
            $display("FAIL play_drain: got %0d items left, required 0",
                     exp_rd_q.size() + exp_l_q.size() + exp_r_q.size());
        end
        dac_mode = 0;
    endtask

    task automatic test_loop();
        int base;
        bit hit = 1'b0;
        wait_cycles = 1;
        start_record();
        send_frame(16'hAAAA, 16'hBBBB, 1'b0);
        send_frame(16'hCCCC, 16'hDDDD, 1'b1);
        wait_writes(100);
        wait_state(S_CAP, 20, "loop_cap");
        pulse(2);
        wait_state(S_IDLE, 20, "loop_rec_idle");
        checks++;
        if (rec_len !== 8'd2) begin
            errors++;
            $display("FAIL loop_len: got %0d, required 2", rec_len);
        end
        for (int i = 0; i < 8; i++) begin
            exp_rd_q.push_back(ADDR_W'(i % 2));
            exp_l_q.push_back((i % 2) ? 16'hCCCC : 16'hAAAA);
            exp_r_q.push_back((i % 2) ? 16'hDDDD : 16'hBBBB);
        end
        loop_in = 1'b1;
        base = read_count;
        pulse(1);
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (read_count - base >= 5 && state === S_RD) hit = 1'b1;
        end
        pulse(2);
        wait_state(S_IDLE, 40, "loop_stop_idle");
        loop_in = 1'b0;
        checks++;
        if (read_count - base < 5) begin
            errors++;
            $display("FAIL loop_reads: got %0d reads, required at least 5", read_count - base);
        end
        exp_rd_q.delete(); exp_l_q.delete(); exp_r_q.delete();
    endtask

    task automatic test_full();
        int wc;
        wait_cycles = 0;
        start_record();
        for (int i = 0; i < 4; i++)
            send_frame(DATA_W'(16'h0100 + i), DATA_W'(16'h0200 + i), i[0]);
        wait_state(S_IDLE, 40, "full_idle");
        checks++;
        if (full !== 1'b1 || rec_len !== 8'd4 || exp_w_q.size() != 0) begin
            errors++;
            $display("FAIL full_flags: got full=%b rec_len=%0d pending=%0d, required 1/4/0",
                     full, rec_len, exp_w_q.size());
        end
        wc = write_count;
        @(posedge clk); #1;
        adc_l_valid = 1'b1; adc_r_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({adc_l_ready, adc_r_ready} !== 2'b00) begin
                errors++;
                $display("FAIL full_ready: got %b, required 00", {adc_l_ready, adc_r_ready});
            end
        end
        @(posedge clk); #1;
        adc_l_valid = 1'b0; adc_r_valid = 1'b0;
        checks++;
        if (write_count != wc || state !== S_IDLE) begin
            errors++;
            $display("FAIL full_extra: got %0d extra writes st=%0d, required 0/0", write_count - wc, state);
        end
    endtask

    task automatic test_pause();
        bit got = 1'b0;
        wait_cycles = 1;
        start_record();
        exp_w_q.push_back({8'h00, 16'hABCD, 16'h1234});
        exp_addr = 8'd1;
        send_ch(1'b0, 16'h1234);
        @(posedge clk); #1;
        pause_in = 1'b1;
        adc_l_valid = 1'b1; adc_l_data = 16'hABCD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (adc_l_ready !== 1'b0 || state !== S_CAP) begin
                errors++;
                $display("FAIL pause_cap: got ready=%b st=%0d, required 0/%0d", adc_l_ready, state, S_CAP);
            end
        end
        @(posedge clk); #1;
        pause_in = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (adc_l_ready) got = 1'b1;
        end
        @(posedge clk); #1;
        adc_l_valid = 1'b0;
        wait_writes(50);
        wait_state(S_CAP, 20, "pause_cap_back");
        pulse(2);
        wait_state(S_IDLE, 20, "pause_rec_idle");
        checks++;
        if (rec_len !== 8'd1 || full !== 1'b0) begin
            errors++;
            $display("FAIL pause_len: got rec_len=%0d full=%b, required 1/0", rec_len, full);
        end
        exp_rd_q.push_back(8'h00);
        exp_l_q.push_back(16'hABCD);
        exp_r_q.push_back(16'h1234);
        pause_in = 1'b1;
        pulse(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_read !== 1'b0 || state !== S_RD) begin
                errors++;
                $display("FAIL pause_rd: got read=%b st=%0d, required 0/%0d", mem_read, state, S_RD);
            end
        end
        @(posedge clk); #1;
        pause_in = 1'b0;
        wait_state(S_IDLE, 60, "pause_play_idle");
        checks++;
        if (exp_rd_q.size() + exp_l_q.size() + exp_r_q.size() != 0) begin
            errors++;
            $display("FAIL pause_drain: got %0d items left, required 0",
                     exp_rd_q.size() + exp_l_q.size() + exp_r_q.size());
        end
    endtask

    task automatic test_stop_wr();
        wait_cycles = 6;
        start_record();
        send_frame(16'h0F0F, 16'hF0F0, 1'b0);
        wait_state(S_WR, 20, "stopwr_wr");
        pulse(2);
        @(negedge clk);
        checks++;
        if (state !== S_WR || mem_write !== 1'b1) begin
            errors++;
            $display("FAIL stopwr_hold: got st=%0d write=%b, required %0d/1", state, mem_write, S_WR);
        end
        wait_state(S_IDLE, 30, "stopwr_idle");
        checks++;
        if (rec_len !== 8'd1 || exp_w_q.size() != 0) begin
            errors++;
            $display("FAIL stopwr_len: got rec_len=%0d pending=%0d, required 1/0", rec_len, exp_w_q.size());
        end
    endtask

    task automatic test_async_reset();
        wait_cycles = 1;
        rd_lat = 6;
        exp_rd_q.push_back(8'h00);
        pulse(1);
        wait_state(S_RWAIT, 20, "areset_rwait");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, mem_read, mem_write, dac_l_valid, dac_r_valid, full} !== '0) begin
            errors++;
            $display("FAIL areset_ctrl: got st=%0d rd=%b wr=%b dv=%b%b full=%b, required all 0",
                     state, mem_read, mem_write, dac_l_valid, dac_r_valid, full);
        end
        checks++;
        if ({mem_addr, rec_len, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL areset_regs: got addr=%0h rec_len=%0d wd=%h, required 0", mem_addr, rec_len, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (state !== S_IDLE || {dac_l_valid, dac_r_valid} !== 2'b00) begin
            errors++;
            $display("FAIL areset_after: got st=%0d dv=%b%b, required 0/00", state, dac_l_valid, dac_r_valid);
        end
        rd_lat = 2;
        exp_rd_q.delete(); exp_l_q.delete(); exp_r_q.delete();
    endtask

    initial begin
        test_reset();
        test_record();
        test_playback();
        test_loop();
        test_full();
        test_pause();
        test_stop_wr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
